// File: rtl/kgp_isa_pkg.sv
// Shared KGP-RISC front-end definitions: fetch FSM state encoding,
// instruction field bit positions, instruction width and NOP encoding.
package kgp_isa_pkg;

   localparam int INSTR_W = 32;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM16_MSB  = 15;
   localparam int IMM16_LSB  = 0;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_decode_stage_fetch_fsm.sv
// Fetch sequencing FSM: state register plus next-state, request and
// capture/drain strobes. Ports: clk, rst (sync active-low), imem_ack,
// redirect, id_ready in; imem_req, id_valid, capture, drain out.
module fetch_fsm
   import kgp_isa_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic imem_ack,
   input  logic redirect,
   input  logic id_ready,
   output logic imem_req,
   output logic id_valid,
   output logic capture,
   output logic drain
);

   fetch_state_e state_q;
   fetch_state_e state_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            // A redirect with no ack leaves a request in flight that
            // must be drained before the new target can be fetched.
            if (redirect) begin
               state_d = imem_ack ? S_FETCH : S_DRAIN;
            end else if (imem_ack) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect || id_ready) begin
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (imem_ack) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign imem_req = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign id_valid = (state_q == S_HOLD);
   assign drain    = (state_q == S_DRAIN);
   assign capture  = (state_q == S_FETCH) && imem_ack && !redirect;

endmodule

// File: rtl/fetch_decode_stage.sv
// KGP-RISC fetch/decode front end: PC, imem req/ack, instruction latch,
// field split, valid/ready to decode, branch redirect handling.
// Ports: clk, rst (sync active-low); imem_req/addr/ack/rdata;
// redirect/redirect_pc; id_valid/ready/pc/instr and decoded fields.
// Optional: FETCH_PERF_CNT_EN adds perf_fetched and perf_stall counters.
module fetch_decode_stage
   import kgp_isa_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [31:0]        id_pc,
   output logic [INSTR_W-1:0] id_instr,
   output logic [5:0]         id_opcode,
   output logic [4:0]         id_rs,
   output logic [4:0]         id_rt,
   output logic [5:0]         id_funct,
   output logic [15:0]        id_imm16
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall
`endif
);

   logic               capture;
   logic               drain;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        addr_q, addr_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [31:0]        ipc_q, ipc_d;

   fetch_fsm u_fsm (
      .clk      (clk),
      .rst      (rst),
      .imem_ack (imem_ack),
      .redirect (redirect),
      .id_ready (id_ready),
      .imem_req (imem_req),
      .id_valid (id_valid),
      .capture  (capture),
      .drain    (drain)
   );

   always_comb begin
      pc_d    = pc_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      // Track the in-flight address so a drain keeps presenting it
      // after pc has already moved to the redirect target.
      if (imem_req && !drain) begin
         addr_d = pc_q;
      end
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (capture) begin
         pc_d = pc_q + PC_STEP;
      end
      if (capture) begin
         instr_d = imem_rdata;
         ipc_d   = pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         instr_q <= NOP_INSTR;
         ipc_q   <= 32'h0;
      end else begin
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   assign imem_addr = drain ? addr_q : pc_q;
   assign id_pc     = ipc_q;
   assign id_instr  = instr_q;
   assign id_opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign id_rs     = instr_q[RS_MSB:RS_LSB];
   assign id_rt     = instr_q[RT_MSB:RT_LSB];
   assign id_funct  = instr_q[FUNCT_MSB:FUNCT_LSB];
   assign id_imm16  = instr_q[IMM16_MSB:IMM16_LSB];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] stall_q, stall_d;

   always_comb begin
      fetched_d = fetched_q;
      stall_d   = stall_q;
      if (id_valid && id_ready && !redirect) begin
         fetched_d = fetched_q + 32'd1;
      end
      if (imem_req && !imem_ack) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetched_q <= 32'h0;
         stall_q   <= 32'h0;
      end else begin
         fetched_q <= fetched_d;
         stall_q   <= stall_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
`endif

endmodule
